enemy_mover: RTL and testbench

Parametrised enemy-movement engine for the tile grid. On each permitted tick it raster-scans the grid RAM and moves every enemy tile by one cell into an adjacent air tile. Each enemy moves at most once per scan, and a blocked enemy retries alternative directions. It sits beside the renderer and player logic, shares the grid RAM port through the top-level arbiter, and is sequenced by the game controller via `start`/`done`.

---
 rtl/enemy_mover.sv | 257 +++++++++++++++++++++++++
 tb/tb_enemy_mover.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_mover.sv
// enemy_mover: tile-grid enemy movement engine.
//
// Each permitted pass raster-scans the grid RAM twice. Pass 1 moves every
// enemy tile one cell into an adjacent air tile, marking it with MOVED_CODE
// so that it cannot be matched again later in the same scan. Pass 2 turns
// every MOVED_CODE cell back into ENEMY_CODE.
//
// Ports:
//   clock, reset            - clock, asynchronous active-high reset
//   start / done / busy     - pass request, one-cycle completion pulse, activity
//   grid_x, grid_y          - registered RAM address (read latency 1)
//   grid_out                - RAM read data for the previous cycle's address
//   grid_write, grid_in     - registered write strobe and write data
//   player_x, player_y      - player position (chase mode only)
//
// Build option: define ENEMY_CHASE_EN to aim each enemy's first attempt at
// the player instead of using the LFSR direction.
//
// Directions: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1).

module enemy_mover #(
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int X_W         = 6,
    parameter int Y_W         = 5,
    parameter int TILE_W      = 3,
    parameter int AIR_CODE    = 0,
    parameter int ENEMY_CODE  = 4,
    parameter int MOVED_CODE  = 5,
    parameter int TICK_CYCLES = 200000,
    parameter int MAX_TRIES   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [X_W-1:0]    grid_x,
    output logic [Y_W-1:0]    grid_y,
    input  logic [TILE_W-1:0] grid_out,
    output logic              grid_write,
    output logic [TILE_W-1:0] grid_in,
    input  logic [X_W-1:0]    player_x,
    input  logic [Y_W-1:0]    player_y
);

    localparam int TMR_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(TICK_CYCLES - 1);
    localparam logic [X_W-1:0]    X_LAST     = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(GRID_H - 1);
    localparam logic [TILE_W-1:0] AIR_T      = TILE_W'(AIR_CODE);
    localparam logic [TILE_W-1:0] ENEMY_T    = TILE_W'(ENEMY_CODE);
    localparam logic [TILE_W-1:0] MOVED_T    = TILE_W'(MOVED_CODE);
    localparam logic [2:0]        MAX_T      = 3'(MAX_TRIES);

    typedef enum logic [3:0] {
        S_IDLE, S_READ, S_CHECK, S_PICK, S_PROBE, S_COMPARE,
        S_WRITE_NEW, S_WRITE_OLD, S_RESTORE, S_NEXT, S_DONE
    } state_t;

    state_t            state_q;
    logic              pass2_q;
    logic [X_W-1:0]    cx_q;
    logic [Y_W-1:0]    cy_q;
    logic [1:0]        dir_q;
    logic [2:0]        tries_q;
    logic              oob_q;
    logic              done_q, busy_q, grid_write_q;
    logic [X_W-1:0]    grid_x_q;
    logic [Y_W-1:0]    grid_y_q;
    logic [TILE_W-1:0] grid_in_q;
    logic [TMR_W-1:0]  timer_q;
    logic              ready_q;
    logic [7:0]        lfsr_q;

    logic              scan_go;
    logic [1:0]        first_dir;
    logic [1:0]        probe_dir;
    int                nx_int, ny_int;
    logic              nbr_oob;
    logic [X_W-1:0]    nbr_x;
    logic [Y_W-1:0]    nbr_y;

    assign done       = done_q;
    assign busy       = busy_q;
    assign grid_x     = grid_x_q;
    assign grid_y     = grid_y_q;
    assign grid_write = grid_write_q;
    assign grid_in    = grid_in_q;

    assign scan_go = (state_q == S_IDLE) && start && ready_q;

`ifdef ENEMY_CHASE_EN
    int dx, dy, adx, ady;
    always_comb begin
        dx  = int'(player_x) - int'(cx_q);
        dy  = int'(player_y) - int'(cy_q);
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        if (dx == 0 && dy == 0)
            first_dir = lfsr_q[1:0];
        else if (adx >= ady)        // tie favours the horizontal axis
            first_dir = (dx > 0) ? 2'd1 : 2'd3;
        else
            first_dir = (dy > 0) ? 2'd2 : 2'd0;
    end
`else
    logic unused_player;
    assign unused_player = ^{player_x, player_y};
    assign first_dir     = lfsr_q[1:0];
`endif

    // Neighbour for the attempt being set up: the first direction in PICK,
    // the next rotation when retrying from PROBE/COMPARE.
    always_comb begin
        probe_dir = (state_q == S_PICK) ? first_dir : dir_q + 2'd1;
        nx_int    = int'(cx_q);
        ny_int    = int'(cy_q);
        case (probe_dir)
            2'd0:    ny_int = ny_int - 1;
            2'd1:    nx_int = nx_int + 1;
            2'd2:    ny_int = ny_int + 1;
            default: nx_int = nx_int - 1;
        endcase
        nbr_oob = (nx_int < 0) || (nx_int >= GRID_W) ||
                  (ny_int < 0) || (ny_int >= GRID_H);
        nbr_x   = X_W'(nx_int);
        nbr_y   = Y_W'(ny_int);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q <= TMR_RELOAD;
            ready_q <= 1'b0;
        end else if (scan_go) begin
            timer_q <= TMR_RELOAD;
            ready_q <= 1'b0;
        end else if (timer_q == '0) begin
            ready_q <= 1'b1;
        end else begin
            timer_q <= timer_q - TMR_W'(1);
        end
    end

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr_q <= 8'h01;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pass2_q      <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            dir_q        <= '0;
            tries_q      <= '0;
            oob_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            grid_write_q <= 1'b0;
            grid_x_q     <= '0;
            grid_y_q     <= '0;
            grid_in_q    <= '0;
        end else begin
            done_q       <= 1'b0;
            grid_write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (ready_q) begin
                            pass2_q  <= 1'b0;
                            cx_q     <= '0;
                            cy_q     <= '0;
                            grid_x_q <= '0;
                            grid_y_q <= '0;
                            state_q  <= S_READ;
                        end else begin
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_READ: state_q <= S_CHECK;
                S_CHECK: begin
                    if (!pass2_q && grid_out == ENEMY_T) begin
                        state_q <= S_PICK;
                    end else if (pass2_q && grid_out == MOVED_T) begin
                        grid_write_q <= 1'b1;
                        grid_in_q    <= ENEMY_T;
                        state_q      <= S_RESTORE;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_PICK, S_PROBE, S_COMPARE: begin
                    if (state_q == S_COMPARE && grid_out == AIR_T) begin
                        // address still holds the neighbour
                        grid_write_q <= 1'b1;
                        grid_in_q    <= MOVED_T;
                        state_q      <= S_WRITE_NEW;
                    end else if (state_q == S_PROBE && !oob_q) begin
                        state_q <= S_COMPARE;
                    end else if (state_q == S_PICK || tries_q < MAX_T) begin
                        dir_q   <= probe_dir;
                        tries_q <= (state_q == S_PICK) ? 3'd1 : tries_q + 3'd1;
                        oob_q   <= nbr_oob;
                        if (!nbr_oob) begin
                            grid_x_q <= nbr_x;
                            grid_y_q <= nbr_y;
                        end
                        state_q <= S_PROBE;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_WRITE_NEW: begin
                    grid_x_q     <= cx_q;
                    grid_y_q     <= cy_q;
                    grid_write_q <= 1'b1;
                    grid_in_q    <= AIR_T;
                    state_q      <= S_WRITE_OLD;
                end
                S_WRITE_OLD, S_RESTORE: state_q <= S_NEXT;
                S_NEXT: begin
                    if (cx_q == X_LAST) begin
                        cx_q     <= '0;
                        grid_x_q <= '0;
                        if (cy_q == Y_LAST) begin
                            cy_q     <= '0;
                            grid_y_q <= '0;
                            pass2_q  <= 1'b1;
                            state_q  <= pass2_q ? S_DONE : S_READ;
                        end else begin
                            cy_q     <= cy_q + Y_W'(1);
                            grid_y_q <= cy_q + Y_W'(1);
                            state_q  <= S_READ;
                        end
                    end else begin
                        cx_q     <= cx_q + X_W'(1);
                        grid_x_q <= cx_q + X_W'(1);
                        grid_y_q <= cy_q;
                        state_q  <= S_READ;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_mover.sv
// Testbench for enemy_mover on a small 8x6 grid with a behavioural grid RAM.
module tb_enemy_mover;

    localparam int GW = 8, GH = 6, XW = 4, YW = 3, TW = 3;
    localparam int AIR = 0, WALL = 1, ENEMY = 4, MOVED = 5;
    localparam int TICK = 10, MAXT = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          done, busy, grid_write;
    logic [XW-1:0] grid_x;
    logic [YW-1:0] grid_y;
    logic [TW-1:0] grid_out, grid_in;
    logic [XW-1:0] player_x = '0;
    logic [YW-1:0] player_y = '0;

    logic [TW-1:0] mem    [GH][GW];
    logic [TW-1:0] init_g [GH][GW];
    logic [TW-1:0] exp_g  [GH][GW];
    logic          load = 1'b0;
    int            wr_cnt = 0, oob_cnt = 0, edge_cnt = 0;
    int            checks = 0, failures = 0;

    enemy_mover #(
        .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .TILE_W(TW),
        .AIR_CODE(AIR), .ENEMY_CODE(ENEMY), .MOVED_CODE(MOVED),
        .TICK_CYCLES(TICK), .MAX_TRIES(MAXT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .done(done), .busy(busy),
        .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out),
        .grid_write(grid_write), .grid_in(grid_in),
        .player_x(player_x), .player_y(player_y)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // grid RAM: registered read, read-before-write
    always @(posedge clock) begin
        if (load) begin
            for (int y = 0; y < GH; y++)
                for (int x = 0; x < GW; x++)
                    mem[y][x] <= init_g[y][x];
        end else if (grid_write) begin
            wr_cnt <= wr_cnt + 1;
            if (int'(grid_x) < GW && int'(grid_y) < GH) mem[grid_y][grid_x] <= grid_in;
        end
        if (int'(grid_x) < GW && int'(grid_y) < GH) grid_out <= mem[grid_y][grid_x];
        else begin
            grid_out <= '0;
            oob_cnt  <= oob_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] l = 8'h01;
        for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    function automatic int count_code(input int code);
        int c = 0;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                if (int'(mem[y][x]) == code) c++;
        return c;
    endfunction

    // Cell-level reference: cycle costs from the timing rules locate the
    // PICK cycle of each enemy, which fixes the LFSR direction it sees.
    task automatic run_model(input int s, output int done_cyc, output int nwr);
        int t = s;
        nwr = 0;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) begin
                if (int'(exp_g[y][x]) == ENEMY) begin
                    logic [7:0] l;
                    int d;
                    bit moved = 0;
                    l = lfsr_at(t + 2);
                    d = int'(l[1:0]);
`ifdef ENEMY_CHASE_EN
                    begin
                        int dx = int'(player_x) - x, dy = int'(player_y) - y;
                        int adx = dx < 0 ? -dx : dx, ady = dy < 0 ? -dy : dy;
                        if (!(dx == 0 && dy == 0)) begin
                            if (adx >= ady) d = dx > 0 ? 1 : 3;
                            else            d = dy > 0 ? 2 : 0;
                        end
                    end
`endif
                    t += 3;
                    for (int a = 0; a < MAXT && !moved; a++) begin
                        int nx = x, ny = y;
                        case (d)
                            0: ny--;
                            1: nx++;
                            2: ny++;
                            default: nx--;
                        endcase
                        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) t += 1;
                        else begin
                            t += 2;
                            if (int'(exp_g[ny][nx]) == AIR) begin
                                exp_g[ny][nx] = TW'(MOVED);
                                exp_g[y][x]   = TW'(AIR);
                                moved = 1;
                                t += 2;
                                nwr += 2;
                            end
                        end
                        if (!moved) d = (d + 1) % 4;
                    end
                    t += 1;
                end else t += 3;
            end
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) begin
                t += 3;
                if (int'(exp_g[y][x]) == MOVED) begin
                    exp_g[y][x] = TW'(ENEMY);
                    t += 1;
                    nwr++;
                end
            end
        done_cyc = t + 1;
    endtask

    task automatic fill(input int code);
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                init_g[y][x] = TW'(code);
    endtask

    task automatic load_grid();
        @(negedge clock); load = 1'b1;
        @(negedge clock); load = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            check_eq({tag, "_done_cycle"}, edge_cnt, exp_cyc);
            @(negedge clock);
            check_eq({tag, "_done_pulse"}, 32'(done), 0);
            check_eq({tag, "_busy_after"}, 32'(busy), 0);
        end
    endtask

    task automatic run_scan(input string tag, output int writes);
        int s, dc, nw, wb, ob, mism;
        load_grid();
        repeat (15) @(negedge clock);
        exp_g = init_g;
        wb = wr_cnt;
        ob = oob_cnt;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; s = edge_cnt; start = 1'b0;
        run_model(s, dc, nw);
        @(negedge clock);
        check_eq({tag, "_busy"}, 32'(busy), 1);
        wait_done(tag, dc);
        writes = wr_cnt - wb;
        check_eq({tag, "_writes"}, writes, nw);
        check_eq({tag, "_oob_addr"}, oob_cnt - ob, 0);
        mism = 0;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                if (mem[y][x] !== exp_g[y][x]) mism++;
        check_eq({tag, "_grid_mismatches"}, mism, 0);
        check_eq({tag, "_moved_left"}, count_code(MOVED), 0);
    endtask

    initial begin
        int wr, wb;
        fill(AIR);
        #23;
        @(negedge clock); reset = 1'b0;

        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_write", 32'(grid_write), 0);
        check_eq("rst_grid_in", 32'(grid_in), 0);
        check_eq("rst_grid_x", 32'(grid_x), 0);
        check_eq("rst_grid_y", 32'(grid_y), 0);

        // timer not yet expired: start in cycle 3 -> done in cycle 5, no traffic
        wb = wr_cnt;
        while (edge_cnt < 3) @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(negedge clock);
        check_eq("nr_busy", 32'(busy), 1);
        check_eq("nr_done_early", 32'(done), 0);
        @(negedge clock);
        check_eq("nr_done", 32'(done), 1);
        check_eq("nr_done_cycle", edge_cnt, 5);
        @(negedge clock);
        check_eq("nr_done_pulse", 32'(done), 0);
        check_eq("nr_writes", wr_cnt - wb, 0);

        // single enemy in open air always moves
        fill(AIR);
        init_g[3][5] = TW'(ENEMY);
        run_scan("single", wr);
        check_eq("single_wr3", wr, 3);
        check_eq("single_src_air", 32'(mem[3][5]), AIR);
        check_eq("single_enemies", count_code(ENEMY), 1);

        // row of enemies boxed by walls, one air cell to the right
        fill(WALL);
        for (int x = 1; x <= 4; x++) init_g[2][x] = TW'(ENEMY);
        init_g[2][5] = TW'(AIR);
        run_scan("row", wr);
        check_eq("row_e1", 32'(mem[2][1]), ENEMY);
        check_eq("row_e2", 32'(mem[2][2]), ENEMY);
        check_eq("row_e3", 32'(mem[2][3]), ENEMY);
        check_eq("row_enemies", count_code(ENEMY), 4);

        // corner enemy fully enclosed: no writes, no out-of-grid address
        fill(WALL);
        init_g[0][0] = TW'(ENEMY);
        run_scan("corner", wr);
        check_eq("corner_wr0", wr, 0);
        check_eq("corner_stay", 32'(mem[0][0]), ENEMY);

        // reset in the middle of pass 1
        fill(AIR);
        init_g[1][2] = TW'(ENEMY);
        init_g[4][6] = TW'(ENEMY);
        load_grid();
        repeat (15) @(negedge clock);
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (40) @(negedge clock);
        check_eq("mid_busy", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_done", 32'(done), 0);
        check_eq("mid_rst_write", 32'(grid_write), 0);
        check_eq("mid_rst_grid_in", 32'(grid_in), 0);
        check_eq("mid_rst_grid_x", 32'(grid_x), 0);
        check_eq("mid_rst_grid_y", 32'(grid_y), 0);
        @(negedge clock); reset = 1'b0;
        run_scan("after_rst", wr);
        check_eq("after_rst_wr", wr, 6);
        check_eq("after_rst_enemies", count_code(ENEMY), 2);

`ifdef ENEMY_CHASE_EN
        fill(AIR);
        init_g[4][3] = TW'(ENEMY);
        player_x = XW'(3);
        player_y = YW'(1);
        run_scan("chase", wr);
        check_eq("chase_dest", 32'(mem[3][3]), ENEMY);
        check_eq("chase_src", 32'(mem[4][3]), AIR);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
